// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter. A parallel word accepted on a
// valid/ready handshake goes out LSB first as start bit, data bits, optional
// parity bit and stop bit. Each bit is held for CLKS_PER_BIT cycles and the
// line idles high. Every output is a register.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Period count one before the last; only reached when CLKS_PER_BIT > 1.
  localparam logic [CNT_W-1:0] PER_PEN  = CNT_W'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  // With one-cycle bits, the stop bit's first cycle is also its last.
  localparam logic STOP_DONE_AT_ENTRY = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even parity by default, inverted for odd parity.
  function automatic logic frame_parity(input logic [DATA_W-1:0] word);
    return (^word) ^ (PARITY_ODD != 0);
  endfunction

  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_r;
  logic [CNT_W-1:0]  per_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              tx_out_r;
  logic              done_r;
  logic              ready_r;
  logic              busy_r;

  logic [DATA_W-1:0] shift_dn_s;
  logic              per_last_s;
  logic              bit_last_s;

  assign shift_dn_s = shift_r >> 1;
  assign per_last_s = (per_cnt_r == PER_LAST);
  assign bit_last_s = (bit_cnt_r == BIT_LAST);

  assign tx_ready = ready_r;
  assign tx_out   = tx_out_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Frame FSM: sequences the bits, runs both counters and loads each output
  // register with its value for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      par_r     <= 1'b0;
      per_cnt_r <= '0;
      bit_cnt_r <= '0;
      tx_out_r  <= 1'b1;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          per_cnt_r <= '0;
          bit_cnt_r <= '0;
          done_r    <= 1'b0;
          if (tx_valid) begin
            shift_r  <= tx_data;
            par_r    <= frame_parity(tx_data);
            state_r  <= ST_START;
            tx_out_r <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            tx_out_r <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
          end
        end
        ST_START: begin
          if (per_last_s) begin
            per_cnt_r <= '0;
            state_r   <= ST_DATA;
            tx_out_r  <= shift_r[0];
          end else begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (per_last_s) begin
            per_cnt_r <= '0;
            if (bit_last_s) begin
              bit_cnt_r <= '0;
              if (PARITY_EN != 0) begin
                state_r  <= ST_PARITY;
                tx_out_r <= par_r;
              end else begin
                state_r  <= ST_STOP;
                tx_out_r <= 1'b1;
                done_r   <= STOP_DONE_AT_ENTRY;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              shift_r   <= shift_dn_s;
              tx_out_r  <= shift_dn_s[0];
            end
          end else begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (per_last_s) begin
            per_cnt_r <= '0;
            state_r   <= ST_STOP;
            tx_out_r  <= 1'b1;
            done_r    <= STOP_DONE_AT_ENTRY;
          end else begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (per_last_s) begin
            per_cnt_r <= '0;
            state_r   <= ST_IDLE;
            tx_out_r  <= 1'b1;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
          end else begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
            done_r    <= (per_cnt_r == PER_PEN);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          per_cnt_r <= '0;
          bit_cnt_r <= '0;
          tx_out_r  <= 1'b1;
          done_r    <= 1'b0;
          ready_r   <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx. Three instances: 0 = 8 bits/4 clk/even
// parity, 1 = 8 bits/4 clk/odd parity, 2 = 8 bits/1 clk/no parity.
// Stimulus pushes the hand-computed line pattern of each frame into that
// instance's queue; a per-instance monitor pops it when busy rises and checks
// every line cycle, the done pulse and the idle state that follows.
module tb_serial_frame_tx;

  typedef struct {
    logic [15:0] bits;   // line bit i of the frame in bit i (start bit first)
    int          n;      // number of line bits in the frame
    bit          abort;  // frame is expected to be cut short by reset
  } exp_t;

  logic            clk;
  logic            rst;
  logic [2:0][7:0] data_v;
  logic [2:0]      valid_v;
  logic [2:0]      ready_v;
  logic [2:0]      line_v;
  logic [2:0]      busy_v;
  logic [2:0]      done_v;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc_cnt = 0;
  exp_t exp_q [3][$];

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_out(line_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_out(line_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
    .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_out(line_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time handshakes against each other.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int cpb(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", name, k, act, exp, cyc_cnt);
    end
  endtask

  task automatic push(input int k, input logic [15:0] bits, input int n, input bit abort);
    exp_t e;
    e.bits = bits;
    e.n = n;
    e.abort = abort;
    exp_q[k].push_back(e);
  endtask

  // Per-instance monitor: samples on the falling edge.
  task automatic monitor(input int k);
    exp_t e;
    bit   in_frame = 1'b0;
    int   cyc = 0;
    int   c = cpb(k);
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_frame) check("abort_expected", k, 16'(e.abort), 16'd1);
        in_frame = 1'b0;
      end else begin
        if (!in_frame && busy_v[k]) begin
          if (exp_q[k].size() == 0) begin
            check("unexpected_frame", k, 16'(busy_v[k]), 16'd0);
          end else begin
            e = exp_q[k].pop_front();
            in_frame = 1'b1;
            cyc = 0;
          end
        end
        if (in_frame) begin
          check("line_bit", k, 16'(line_v[k]), 16'(e.bits[cyc / c]));
          check("done_timing", k, 16'(done_v[k]), 16'(cyc == e.n * c - 1));
          check("ready_low_in_frame", k, 16'(ready_v[k]), 16'd0);
          cyc++;
          if (cyc == e.n * c) begin
            in_frame = 1'b0;
            check("frame_not_aborted", k, 16'(e.abort), 16'd0);
          end
        end else if (!busy_v[k]) begin
          check("idle_line", k, 16'(line_v[k]), 16'd1);
          check("idle_done", k, 16'(done_v[k]), 16'd0);
          check("idle_ready", k, 16'(ready_v[k]), 16'd1);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Offer a word until accepted (bounded); returns the handshake cycle number.
  task automatic send(input int k, input logic [7:0] d, input bit hold, output int hs_cyc);
    bit got = 1'b0;
    data_v[k] = d;
    valid_v[k] = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = ready_v[k];
      @(posedge clk);
      #1;
    end
    hs_cyc = cyc_cnt;
    check("handshake", k, 16'(got), 16'd1);
    if (!hold) valid_v[k] = 1'b0;
  endtask

  // Wait (bounded) until the instance is idle with nothing left to check.
  task automatic wait_idle(input int k);
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = !busy_v[k] && (exp_q[k].size() == 0);
    end
    check("wait_idle", k, 16'(idle), 16'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1;
    int n2;
    rst = 1'b1;
    valid_v = 3'b111;
    data_v[0] = 8'hA5;
    data_v[1] = 8'hA5;
    data_v[2] = 8'hA5;

    // 1: reset held two edges with tx_valid high; no frame may start.
    @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_line", k, 16'(line_v[k]), 16'd1);
      check("rst_ready", k, 16'(ready_v[k]), 16'd1);
      check("rst_busy", k, 16'(busy_v[k]), 16'd0);
      check("rst_done", k, 16'(done_v[k]), 16'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_v = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    // 2: 0xA5, even parity (4 ones -> parity 0).
    push(0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0);
    send(0, 8'hA5, 1'b0, n1);
    wait_idle(0);

    // 3: 0x01 odd parity -> 0; even parity -> 1.
    push(1, 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 1'b0);
    send(1, 8'h01, 1'b0, n1);
    wait_idle(1);
    push(0, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 1'b0);
    send(0, 8'h01, 1'b0, n1);
    wait_idle(0);

    // 4: back-to-back 0xFF then 0x00 with tx_valid held and tx_data disturbed.
    push(0, 16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, 1'b0);
    push(0, 16'({1'b1, 1'b0, 8'h00, 1'b0}), 11, 1'b0);
    send(0, 8'hFF, 1'b1, n1);
    data_v[0] = 8'h3C;
    repeat (10) @(posedge clk);
    #1;
    data_v[0] = 8'h81;
    send(0, 8'h00, 1'b0, n2);
    check("b2b_gap", 0, 16'(n2 - n1), 16'd45);
    wait_idle(0);

    // 5: reset during data bit 3 of 0x5A, then 0x3C must be bit-exact.
    push(0, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 1'b1);
    send(0, 8'h5A, 1'b0, n1);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_line", 0, 16'(line_v[0]), 16'd1);
    check("abort_busy", 0, 16'(busy_v[0]), 16'd0);
    check("abort_done", 0, 16'(done_v[0]), 16'd0);
    @(posedge clk);
    #1;
    push(0, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 1'b0);
    send(0, 8'h3C, 1'b0, n1);
    wait_idle(0);

    // 6: one-clock bits, no parity: 0x80 -> 0,0,0,0,0,0,0,0,1,1.
    push(2, 16'({1'b1, 8'h80, 1'b0}), 10, 1'b0);
    send(2, 8'h80, 1'b0, n1);
    wait_idle(2);

    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) check("queue_drained", k, 16'(exp_q[k].size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
